// File: rtl/serial_feeder_pkg.sv
// Shared types and parameter limits for the serial word feeder.
package serial_feeder_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      GAP   = 2'b10
   } state_e;

   localparam int unsigned WIDTH_MIN = 2;
   localparam int unsigned WIDTH_MAX = 32;
   localparam int unsigned GAP_MIN   = 0;
   localparam int unsigned GAP_MAX   = 15;
   localparam int unsigned GAP_CNT_W = 4;

endpackage

// File: rtl/serial_feeder_hold.sv
// One-word skid buffer ahead of the shifter; DIN_READY tracks the empty flag.
module serial_feeder_hold
   import serial_feeder_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic             drain_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             ready_o
);

   logic [WIDTH-1:0] hold_q, hold_d;
   logic             full_q, full_d;
   logic             ready_q;

   always_comb begin
      hold_d = hold_q;
      full_d = full_q;
      if (load_i) begin
         hold_d = data_i;
         full_d = 1'b1;
      end else if (drain_i) begin
         full_d = 1'b0;
      end
   end

   // Ready stays low through reset and rises on the first edge out of it.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         hold_q  <= '0;
         full_q  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         hold_q  <= hold_d;
         full_q  <= full_d;
         ready_q <= !full_d;
      end
   end

   assign data_o  = hold_q;
   assign full_o  = full_q;
   assign ready_o = ready_q;

endmodule

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial feeder: accepts words on valid/ready, shifts them out MSB
// first with optional idle gap cycles between words.
module serial_word_feeder
   import serial_feeder_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned GAP_CYCLES = 0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] DIN,
   input  logic             DIN_VALID,
   output logic             DIN_READY,
   output logic             SOUT,
   output logic             SOUT_VALID,
   output logic             WORD_DONE,
   output logic             BUSY
);

   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [GAP_CNT_W-1:0] GAP_LAST =
      (GAP_CYCLES > 0) ? GAP_CNT_W'(GAP_CYCLES - 1) : '0;

   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("serial_word_feeder: WIDTH out of range");
   end
   if (GAP_CYCLES < GAP_MIN || GAP_CYCLES > GAP_MAX) begin : g_bad_gap
      $error("serial_word_feeder: GAP_CYCLES out of range");
   end

   state_e                 state_q, state_d;
   logic [WIDTH-1:0]       shift_q, shift_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [GAP_CNT_W-1:0]   gap_q, gap_d;
   logic                   sout_q, sout_d;
   logic                   sout_valid_q, sout_valid_d;
   logic                   word_done_q, word_done_d;
   logic                   busy_q, busy_d;

   logic [WIDTH-1:0]       hold_data;
   logic                   hold_full;
   logic                   xfer, free, drain, bypass, load_hold;

   serial_feeder_hold #(.WIDTH(WIDTH)) u_hold (
      .clk_i   (CLK),
      .rst_ni  (RST),
      .load_i  (load_hold),
      .drain_i (drain),
      .data_i  (DIN),
      .data_o  (hold_data),
      .full_o  (hold_full),
      .ready_o (DIN_READY)
   );

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q      <= IDLE;
         shift_q      <= '0;
         cnt_q        <= '0;
         gap_q        <= '0;
         sout_q       <= 1'b0;
         sout_valid_q <= 1'b0;
         word_done_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         cnt_q        <= cnt_d;
         gap_q        <= gap_d;
         sout_q       <= sout_d;
         sout_valid_q <= sout_valid_d;
         word_done_q  <= word_done_d;
         busy_q       <= busy_d;
      end
   end

   always_comb begin
      unique case (state_q)
         IDLE:    free = 1'b1;
         SHIFT:   free = (cnt_q == '0) && (GAP_CYCLES == 0);
         GAP:     free = (gap_q == '0);
         default: free = 1'b1;
      endcase

      xfer      = DIN_VALID && DIN_READY;
      drain     = free && hold_full;
      bypass    = free && !hold_full && xfer;
      load_hold = xfer && !bypass;

      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      gap_d   = gap_q;

      if (drain || bypass) begin
         state_d = SHIFT;
         shift_d = drain ? hold_data : DIN;
         cnt_d   = CNT_LAST;
      end else begin
         unique case (state_q)
            SHIFT: begin
               if (cnt_q != '0) begin
                  shift_d = shift_q << 1;
                  cnt_d   = cnt_q - CNT_W'(1);
               end else if (GAP_CYCLES > 0) begin
                  state_d = GAP;
                  gap_d   = GAP_LAST;
               end else begin
                  state_d = IDLE;
               end
            end
            GAP: begin
               if (gap_q != '0) gap_d = gap_q - GAP_CNT_W'(1);
               else             state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Outputs are computed from next state so they register in step with it.
   always_comb begin
      sout_valid_d = (state_d == SHIFT);
      sout_d       = sout_valid_d && shift_d[WIDTH-1];
      word_done_d  = sout_valid_d && (cnt_d == '0);
      busy_d       = (state_d != IDLE) || load_hold || (hold_full && !drain);
   end

   assign SOUT       = sout_q;
   assign SOUT_VALID = sout_valid_q;
   assign WORD_DONE  = word_done_q;
   assign BUSY       = busy_q;

endmodule

// File: doc/serial_word_feeder.md
# serial_word_feeder

Parallel-to-serial front end for the bit-serial pattern detectors. Accepts WIDTH-bit words over a valid/ready handshake, buffers one word ahead, and drives one bit per clock, MSB first, onto a serial line that connects directly to a detector's IN input. The detector samples every cycle and has no valid input, so this block idles the serial line low between words.

## Interface

- WIDTH, 8: word width in bits; legal range 2..32.
- GAP_CYCLES, 0: forced idle cycles (SOUT=0) inserted between consecutive words; legal range 0..15.

- CLK  in  1  Single clock; all state updates on its rising edge.
- RST  in  1  Synchronous reset, active-low; sampled only on the CLK rising edge.
- DIN  in  WIDTH  Parallel word; bit WIDTH-1 is sent first.
- DIN_VALID  in  1  DIN is presented.
- DIN_READY  out  1  Registered; a word can be accepted this cycle.
- SOUT  out  1  Serial bit to the detector IN; 0 when not shifting.
- SOUT_VALID  out  1  SOUT carries a word bit this cycle.
- WORD_DONE  out  1  High during the cycle the LSB is on SOUT.
- BUSY  out  1  State is not IDLE, or the hold register is full.

## Operation

- Transfer occurs at a CLK edge where DIN_VALID=1 and DIN_READY=1. DIN_VALID with DIN_READY=0 is ignored; no drop flag.
- Storage:
  - shift register (WIDTH)
  - hold register (WIDTH) with hold_full flag
  - bit counter (ceil log2 WIDTH)
  - gap counter (4 bits)
- States:
  - IDLE: SOUT=0, SOUT_VALID=0.
  - SHIFT: SOUT = shift[WIDTH-1], SOUT_VALID=1; shift left each cycle; counter WIDTH-1 down to 0.
  - GAP: SOUT=0, SOUT_VALID=0 for exactly GAP_CYCLES cycles.
- Shifter is "free" at an edge when any of these holds:
  - state IDLE;
  - state SHIFT with counter=0 and GAP_CYCLES=0;
  - state GAP with the gap counter on its last cycle.
- At a free edge:
  - If hold_full, load the hold word into the shifter and clear hold_full.
  - Otherwise, if a transfer occurs at this edge, load DIN directly into the shifter (bypass).
  - Otherwise, go to IDLE, or to GAP if leaving SHIFT with GAP_CYCLES>0.
- A transfer that does not bypass writes the hold register and sets hold_full.
- DIN_READY next value = !hold_full next value. A hold-to-shifter move and a new transfer never occur at the same edge, because DIN_READY is 0 whenever hold_full=1.
- SHIFT with counter=0 and GAP_CYCLES>0 goes to GAP, even if hold_full. The held word loads at the end of GAP.
- Reset (RST=0 at an edge):
  - state IDLE; shift, hold and counters cleared; hold_full=0.
  - Any in-flight or held word is discarded.
  - SOUT=0, SOUT_VALID=0, WORD_DONE=0, BUSY=0, DIN_READY=0.
  - DIN_READY rises at the first edge with RST=1. Words presented while RST=0 are never accepted.

## Timing

- Latency: a word accepted at edge E0 into an idle block has its MSB on SOUT from E0 to E1. Its LSB is on SOUT in cycle E0+WIDTH-1, with WORD_DONE=1 in that cycle.
- Throughput with GAP_CYCLES=0: back-to-back words with no bubble on SOUT, provided each next word is accepted before the current LSB cycle ends.
- Throughput with GAP_CYCLES=G: exactly G zero cycles between LSB and next MSB when the next word is already held.
- DIN_READY, SOUT, SOUT_VALID, WORD_DONE and BUSY are all registered. There is no combinational path from DIN_VALID to any output.

## Structure

- Package serial_feeder_pkg holds:
  - the state encoding localparams (IDLE=2'b00, SHIFT=2'b01, GAP=2'b10);
  - the WIDTH and GAP_CYCLES range limits used by elaboration-time checks.
- One sub-module, serial_feeder_hold: the hold register plus hold_full flag and DIN_READY register. Its ports are load, drain, data in and data out.
- The shift/counter FSM stays in the top module.

## Test plan

- Reset then single word, WIDTH=8: DIN=8'hB0 accepted at E0 -> SOUT 1,0,1,1,0,0,0,0 over E0..E0+7, SOUT_VALID high 8 cycles, WORD_DONE only at E0+7, then SOUT=0, BUSY=0.
- Back-to-back, GAP_CYCLES=0: DIN_VALID held with 8'hB0 then 8'hFF -> 16 contiguous valid bits 10110000 11111111. DIN_READY drops for the cycles hold_full=1.
- Gap insertion, GAP_CYCLES=3: two words 8'h0B, 8'h0B -> 00001011, then 000 with SOUT_VALID=0, then 00001011. Exactly 3 gap cycles.
- Backpressure: DIN_VALID with 8'hAA while shifter busy and hold full -> not accepted until DIN_READY=1. No word lost or duplicated; output order is preserved.
- Reset mid-word: RST=0 at bit 3 of 8'hB0 with a word held -> next cycle SOUT=0, SOUT_VALID=0, DIN_READY=0. After release, the first new word 8'hB0 appears intact and the held word never appears.
- Integration: feed 8'hB0, 8'h0B into the 1011 Moore detector -> detector OUT pulses once per word, on the cycle after that word's final 1 of the 1011.
